pcint0_ctrl: RTL

PCINT0_CTRL -- requirements
Module: pcint0_ctrl

---
 rtl/pcint0_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pcint0_ctrl.sv
// pcint0_ctrl: pin-change interrupt controller for one 8-pin port.
// Pins are synchronised, compared against a history register and, where
// enabled by the mask, set the PCIF0 flag. The flag is cleared by software
// (write 1) or by the vector-taken acknowledge, with set taking priority.
// Optional build macro: PCINT_GLITCH_FILTER_EN adds a third synchroniser
// stage and accepts a pin level only once it has been stable for two cycles.
`timescale 1ns/1ps
module pcint0_ctrl #(
  parameter logic [5:0] PCIFR_Address = 6'h1B,
  parameter logic [5:0] PCICR_Address = 6'h3A,
  parameter logic [5:0] PCMSK_Address = 6'h3B
) (
  input  logic       cp2,
  input  logic       ireset,
  input  logic [5:0] IO_Addr,
  input  logic       iore,
  input  logic       iowe,
  input  logic [7:0] dbus_in,
  output logic [7:0] dbus_out,
  output logic       out_en,
  input  logic [7:0] pin_i,
  output logic [7:0] pcmsk_o,
  output logic       pcie0_o,
  output logic       irq_o,
  input  logic       irq_ack_i
);

  logic [7:0] s1;
  logic [7:0] s2;
  logic [7:0] prev;
  logic [7:0] cmp;
  logic [7:0] change;
  logic [7:0] pcmsk;
  logic       pcif0;
  logic       pcie0;
  logic       wr_pcifr;
  logic       wr_pcicr;
  logic       wr_pcmsk;

  assign wr_pcifr = iowe && (IO_Addr == PCIFR_Address);
  assign wr_pcicr = iowe && (IO_Addr == PCICR_Address);
  assign wr_pcmsk = iowe && (IO_Addr == PCMSK_Address);

`ifdef PCINT_GLITCH_FILTER_EN
  logic [7:0] s3;

  // Third synchroniser stage used only to qualify level stability.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) s3 <= 8'h00;
    else        s3 <= s2;
  end

  // Accept a pin's new level only when s2 and s3 agree; otherwise keep history.
  always_comb begin
    cmp = (s2 & ~(s2 ^ s3)) | (prev & (s2 ^ s3));
  end
`else
  // Without filtering the second synchroniser stage is compared directly.
  always_comb begin
    cmp = s2;
  end
`endif

  // Masked edge detect; history follows every pin regardless of the mask.
  always_comb begin
    change = (cmp ^ prev) & pcmsk;
  end

  // Synchroniser chain and history register.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      s1   <= 8'h00;
      s2   <= 8'h00;
      prev <= 8'h00;
    end else begin
      s1   <= pin_i;
      s2   <= s1;
      prev <= cmp;
    end
  end

  // Flag: a detected change always wins over a simultaneous clear.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      pcif0 <= 1'b0;
    end else if (|change) begin
      pcif0 <= 1'b1;
    end else if ((wr_pcifr && dbus_in[0]) || irq_ack_i) begin
      pcif0 <= 1'b0;
    end
  end

  // Software-writable control and mask registers.
  always_ff @(posedge cp2 or posedge ireset) begin
    if (ireset) begin
      pcie0 <= 1'b0;
      pcmsk <= 8'h00;
    end else begin
      if (wr_pcicr) pcie0 <= dbus_in[0];
      if (wr_pcmsk) pcmsk <= dbus_in;
    end
  end

  // Combinational read mux; unimplemented bits read as zero.
  always_comb begin
    out_en   = 1'b0;
    dbus_out = 8'h00;
    if (iore) begin
      if (IO_Addr == PCIFR_Address) begin
        out_en   = 1'b1;
        dbus_out = {7'b0, pcif0};
      end else if (IO_Addr == PCICR_Address) begin
        out_en   = 1'b1;
        dbus_out = {7'b0, pcie0};
      end else if (IO_Addr == PCMSK_Address) begin
        out_en   = 1'b1;
        dbus_out = pcmsk;
      end
    end
  end

  assign pcmsk_o = pcmsk;
  assign pcie0_o = pcie0;
  assign irq_o   = pcif0 & pcie0;

endmodule
